// File: rtl/tl_xbar_pkg.sv
// Shared TileLink crossbar constants and helpers, used by tl_rr_mux and tl_demux.
package tl_xbar_pkg;

  localparam int TL_N      = 4;
  localparam int TL_DATA_W = 8;
  localparam int TL_SEL_W  = 2;

  // Ceiling log2 for sizing select fields; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Combinational rotate-priority arbiter. Searches req starting at ptr and
// wrapping N-1 -> 0; the first requester found wins.
module tl_rr_arbiter
  import tl_xbar_pkg::*;
#(
  parameter int N     = TL_N,
  parameter int SEL_W = TL_SEL_W
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [SEL_W-1:0] gnt_id,
  output logic             any
);

  logic [N-1:0]     req_rot;
  logic [SEL_W:0]   idx_w;
  logic [SEL_W:0]   sum_w;
  logic [SEL_W-1:0] off;

  // Rotate requests so bit j is the port sitting j places after ptr.
  always_comb begin
    req_rot = '0;
    idx_w   = '0;
    for (int j = 0; j < N; j++) begin
      idx_w = {1'b0, ptr} + (SEL_W+1)'(j);
      if (idx_w >= (SEL_W+1)'(N)) begin
        idx_w = idx_w - (SEL_W+1)'(N);
      end
      for (int i = 0; i < N; i++) begin
        if (idx_w == (SEL_W+1)'(i)) begin
          req_rot[j] = req[i];
        end
      end
    end
  end

  // Lowest set bit of the rotated vector, then map the offset back to a port id.
  always_comb begin
    any    = 1'b0;
    off    = '0;
    gnt_oh = '0;
    for (int j = 0; j < N; j++) begin
      if (!any && req_rot[j]) begin
        any = 1'b1;
        off = SEL_W'(j);
      end
    end
    sum_w = {1'b0, ptr} + {1'b0, off};
    if (sum_w >= (SEL_W+1)'(N)) begin
      sum_w = sum_w - (SEL_W+1)'(N);
    end
    gnt_id = sum_w[SEL_W-1:0];
    for (int k = 0; k < N; k++) begin
      gnt_oh[k] = any && (gnt_id == SEL_W'(k));
    end
  end

endmodule

// File: rtl/tl_rr_mux.sv
// N-to-1 round-robin mux for one TileLink channel. Grant is held for a whole
// multi-beat message; each output beat is tagged with its source port.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   idle   | lock=0: arbitrate from rr_ptr among valid ports
//   locked | lock=1: only lock_id may send until its last beat is taken
module tl_rr_mux
  import tl_xbar_pkg::*;
#(
  parameter int N      = TL_N,
  parameter int DATA_W = TL_DATA_W,
  parameter int SEL_W  = TL_SEL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        valid_i,
  output logic [N-1:0]        ready_o,
  input  logic [N*DATA_W-1:0] data_i,
  input  logic [N-1:0]        last_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                last_o,
  output logic [SEL_W-1:0]    src_o
);

  logic             lock;
  logic [SEL_W-1:0] lock_id;
  logic [SEL_W-1:0] rr_ptr;

  logic [N-1:0]      arb_gnt_oh;
  logic [SEL_W-1:0]  arb_id;
  logic              arb_any;
  logic [N-1:0]      lock_oh;
  logic [SEL_W-1:0]  grant_id;
  logic              can_load;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic [SEL_W-1:0]  next_ptr;

  tl_rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req    (valid_i),
    .ptr    (rr_ptr),
    .gnt_oh (arb_gnt_oh),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  // Grant selection and per-port ready; the locked source only gets ready while it is valid.
  always_comb begin
    lock_oh = '0;
    for (int k = 0; k < N; k++) begin
      lock_oh[k] = (lock_id == SEL_W'(k));
    end
    can_load = !valid_o || ready_i;
    grant_id = lock ? lock_id : arb_id;
    ready_o  = '0;
    if (!rst && can_load) begin
      if (lock) begin
        ready_o = lock_oh & valid_i;
      end else if (arb_any) begin
        ready_o = arb_gnt_oh;
      end
    end
    accept = |ready_o;
  end

  // Payload of the granted port and the pointer that follows it.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant_id == SEL_W'(k)) begin
        sel_data = data_i[k*DATA_W +: DATA_W];
        sel_last = last_i[k];
      end
    end
    next_ptr = (grant_id == SEL_W'(N-1)) ? '0 : grant_id + SEL_W'(1);
  end

  // Output register plus lock/pointer bookkeeping; load and drain may share a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      src_o   <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
      rr_ptr  <= '0;
    end else if (accept) begin
      valid_o <= 1'b1;
      data_o  <= sel_data;
      last_o  <= sel_last;
      src_o   <= grant_id;
      if (sel_last) begin
        lock   <= 1'b0;
        rr_ptr <= next_ptr;
      end else begin
        lock    <= 1'b1;
        lock_id <= grant_id;
      end
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tl_rr_mux.sv
// Self-checking bench for tl_rr_mux: queue-driven sources, behavioural model,
// per-cycle compare plus directed literal expectations.
module tb_tl_rr_mux;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int QD = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  valid_i;
  logic [N-1:0]  ready_o;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]  last_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic [SW-1:0] src_o;

  always #5 clk = ~clk;

  tl_rr_mux #(.N(N), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .last_o  (last_o),
    .src_o   (src_o)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Per-port source queues: beat payload, last flag, idle cycles before presenting.
  logic [DW-1:0] q_data [N][QD];
  bit            q_last [N][QD];
  int            q_gap  [N][QD];
  int            q_hd   [N];
  int            q_tl   [N];

  // Behavioural model state.
  bit            m_vo;
  logic [DW-1:0] m_d;
  bit            m_l;
  int            m_s;
  bit            m_lock;
  int            m_lid;
  int            m_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int qcnt(input int k);
    return q_tl[k] - q_hd[k];
  endfunction

  task automatic push(input int k, input logic [DW-1:0] d, input bit l, input int gap);
    int i;
    i = q_tl[k] % QD;
    q_data[k][i] = d;
    q_last[k][i] = l;
    q_gap[k][i]  = gap;
    q_tl[k]++;
  endtask

  // Who the spec says is granted right now: locked owner, else first valid from m_ptr.
  function automatic int m_grant(output bit gv);
    int g;
    g  = 0;
    gv = 0;
    if (m_lock) begin
      g  = m_lid;
      gv = valid_i[m_lid];
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!gv && valid_i[k]) begin
          gv = 1;
          g  = k;
        end
      end
    end
    return g;
  endfunction

  // Model update at the edge, then sources present their next beat.
  always @(posedge clk) begin : model_p
    int  g;
    bit  gv;
    int  qi;
    if (rst) begin
      m_vo = 0; m_d = '0; m_l = 0; m_s = 0;
      m_lock = 0; m_lid = 0; m_ptr = 0;
    end else begin
      g = m_grant(gv);
      if ((!m_vo || ready_i) && gv) begin
        m_vo = 1;
        m_d  = data_i[g*DW +: DW];
        m_l  = last_i[g];
        m_s  = g;
        if (last_i[g]) begin
          m_lock = 0;
          m_ptr  = (g + 1) % N;
        end else begin
          m_lock = 1;
          m_lid  = g;
        end
        q_hd[g]++;
      end else if (ready_i) begin
        m_vo = 0;
      end
    end
    #1;
    for (int k = 0; k < N; k++) begin
      if (qcnt(k) > 0) begin
        qi = q_hd[k] % QD;
        if (q_gap[k][qi] > 0) begin
          q_gap[k][qi]--;
          valid_i[k] = 1'b0;
          data_i[k*DW +: DW] = 8'($urandom);
          last_i[k] = 1'b0;
        end else begin
          valid_i[k] = 1'b1;
          data_i[k*DW +: DW] = q_data[k][qi];
          last_i[k] = q_last[k][qi];
        end
      end else begin
        valid_i[k] = 1'b0;
        data_i[k*DW +: DW] = 8'($urandom);
        last_i[k] = 1'($urandom);
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin : compare_p
    int           g;
    bit           gv;
    logic [N-1:0] er;
    if (chk_en) begin
      g  = m_grant(gv);
      er = '0;
      if (!rst && (!m_vo || ready_i) && gv) er[g] = 1'b1;
      chk("ready_o", 32'(ready_o), 32'(er));
      chk("valid_o", 32'(valid_o), 32'(m_vo));
      if (m_vo) begin
        chk("data_o", 32'(data_o), 32'(m_d));
        chk("last_o", 32'(last_o), 32'(m_l));
        chk("src_o", 32'(src_o), 32'(m_s));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    bit busy;
    ready_i = 1'b1;
    n = 0;
    busy = 1;
    while (busy && n < 200) begin
      tick();
      n++;
      busy = valid_o;
      for (int k = 0; k < N; k++) if (qcnt(k) > 0) busy = 1;
    end
    chk("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ev;
    logic [7:0] e3 [4];
    int         len;
    e3[0] = 8'hB0; e3[1] = 8'hB1; e3[2] = 8'hB2; e3[3] = 8'hC0;

    rst = 1'b1;
    ready_i = 1'b1;
    valid_i = '0;
    data_i = '0;
    last_i = '0;
    for (int k = 0; k < N; k++) begin
      push(k, 8'(8'hA0 + k), 1'b1, 0);
      push(k, 8'(8'hA0 + k), 1'b1, 0);
    end
    @(posedge clk);
    #3 chk_en = 1;

    // Reset held with every port valid.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_rst_ready", 32'(ready_o), 32'd0);
      chk("t1_rst_valid", 32'(valid_o), 32'd0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_first_grant", 32'(ready_o), 32'b0001);

    // Single-beat round robin.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ev = 8'(8'hA0 + (i % 4));
      chk("t2_data", 32'(data_o), 32'(ev));
      chk("t2_src", 32'(src_o), 32'(i % 4));
    end
    drain();

    // Burst lock on port 1 while port 2 waits.
    push(1, 8'hB0, 1'b0, 0);
    push(1, 8'hB1, 1'b0, 0);
    push(1, 8'hB2, 1'b1, 0);
    push(2, 8'hC0, 1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t3_grant", 32'(ready_o), 32'b0010);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_data", 32'(data_o), 32'(e3[i]));
      if (i < 2) chk("t3_port2_stalled", 32'(ready_o[2]), 32'd0);
    end
    drain();

    // Backpressure with a beat held in the output register.
    ready_i = 1'b0;
    push(3, 8'hD3, 1'b1, 0);
    push(1, 8'h41, 1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_grant", 32'(ready_o), 32'b1000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(valid_o), 32'd1);
      chk("t4_hold_data", 32'(data_o), 32'hD3);
      chk("t4_hold_src", 32'(src_o), 32'd3);
      chk("t4_hold_ready", 32'(ready_o), 32'd0);
    end
    tick();
    ready_i = 1'b1;
    @(negedge clk);
    chk("t4_release_ready", 32'(ready_o), 32'b0010);
    @(negedge clk);
    chk("t4_next_data", 32'(data_o), 32'h41);
    chk("t4_next_src", 32'(src_o), 32'd1);
    drain();

    // Locked source goes idle mid-message.
    push(0, 8'hE0, 1'b0, 0);
    push(0, 8'hE1, 1'b1, 2);
    push(1, 8'hF0, 1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_grant", 32'(ready_o), 32'b0001);
    @(negedge clk);
    chk("t5_e0_valid", 32'(valid_o), 32'd1);
    chk("t5_e0_data", 32'(data_o), 32'hE0);
    chk("t5_gap_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    chk("t5_bubble1", 32'(valid_o), 32'd0);
    chk("t5_bubble1_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    chk("t5_bubble2", 32'(valid_o), 32'd0);
    chk("t5_resume_ready", 32'(ready_o), 32'b0001);
    @(negedge clk);
    chk("t5_e1_data", 32'(data_o), 32'hE1);
    chk("t5_port1_ready", 32'(ready_o), 32'b0010);
    @(negedge clk);
    chk("t5_f0_data", 32'(data_o), 32'hF0);
    chk("t5_f0_src", 32'(src_o), 32'd1);
    drain();

    // Reset while port 2 holds the lock.
    push(2, 8'h60, 1'b0, 0);
    push(2, 8'h61, 1'b1, 5);
    push(0, 8'h70, 1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_grant", 32'(ready_o), 32'b0100);
    @(negedge clk);
    chk("t6_g0_data", 32'(data_o), 32'h60);
    chk("t6_locked_ready", 32'(ready_o), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready", 32'(ready_o), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_after_rst_valid", 32'(valid_o), 32'd0);
    chk("t6_after_rst_grant", 32'(ready_o), 32'b0001);
    @(negedge clk);
    chk("t6_h0_data", 32'(data_o), 32'h70);
    chk("t6_h0_src", 32'(src_o), 32'd0);
    drain();

    // Random traffic: messages of 1..3 beats, random gaps, backpressure, rare reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      ready_i = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        if (qcnt(k) < 4) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            push(k, 8'($urandom), (b == len - 1),
                 ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : 0);
          end
        end
      end
    end
    tick();
    rst = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
